// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcodes, ALU codes, datapath select codes and the decoded control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [3:0] {
        CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       op_a;
        logic       op_b;
        logic [1:0] wb_src;
    } ctrl_t;

    // alt selects SUB/SRA; callers decide when IR[30] is meaningful
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode of the instruction register into the control
// bundle, flagging unknown opcodes and undefined funct3/funct7 combinations.
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int OPCODE      = 7,
    parameter int FUNCTION3   = 3
) (
    input  logic [INSTR_WIDTH-1:0] ir_i,
    output ctrl_t                  ctrl_o,
    output logic                   illegal_o
);

    logic [OPCODE-1:0]    opcode;
    logic [FUNCTION3-1:0] fun3;
    logic                 fun7;
    logic                 unused_ir;

    assign opcode    = ir_i[OPCODE-1:0];
    assign fun3      = ir_i[12 +: FUNCTION3];
    assign fun7      = ir_i[30];
    assign unused_ir = ^{ir_i[INSTR_WIDTH-1:31], ir_i[29:15], ir_i[11:7]};

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.cls    = CL_NONE;
        ctrl_o.alu    = ALU_ADD;
        ctrl_o.imm    = IMM_I;
        ctrl_o.op_b   = 1'b1;
        ctrl_o.wb_src = WB_ALU;
        illegal_o     = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_o.cls  = CL_R;
                ctrl_o.op_b = 1'b0;
                ctrl_o.alu  = alu_from_funct(fun3, fun7);
                illegal_o   = fun7 && (fun3 != 3'b000) && (fun3 != 3'b101);
            end
            OP_I: begin
                // IR[30] is immediate data except on the shift encodings
                ctrl_o.cls = CL_I;
                ctrl_o.alu = alu_from_funct(fun3, fun7 && (fun3 == 3'b101));
                illegal_o  = fun7 && (fun3 == 3'b001);
            end
            OP_LOAD: begin
                ctrl_o.cls    = CL_LOAD;
                ctrl_o.wb_src = WB_MEM;
                illegal_o     = !(fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                ctrl_o.cls = CL_STORE;
                ctrl_o.imm = IMM_S;
                illegal_o  = (fun3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl_o.cls  = CL_BRANCH;
                ctrl_o.imm  = IMM_B;
                ctrl_o.op_a = 1'b1;
                illegal_o   = (fun3 == 3'b010) || (fun3 == 3'b011);
            end
            OP_JAL: begin
                ctrl_o.cls    = CL_JAL;
                ctrl_o.imm    = IMM_J;
                ctrl_o.op_a   = 1'b1;
                ctrl_o.wb_src = WB_PC4;
            end
            OP_JALR: begin
                ctrl_o.cls    = CL_JALR;
                ctrl_o.wb_src = WB_PC4;
                illegal_o     = (fun3 != 3'b000);
            end
            OP_LUI: begin
                ctrl_o.cls = CL_LUI;
                ctrl_o.imm = IMM_U;
                ctrl_o.alu = ALU_PASSB;
            end
            OP_AUIPC: begin
                ctrl_o.cls  = CL_AUIPC;
                ctrl_o.imm  = IMM_U;
                ctrl_o.op_a = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback with fetch and data-memory handshakes and a memory timeout trap.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int FUNCTION3   = 3,
    parameter int OPCODE      = 7,
    parameter int ALU_CONTROL = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   instr_valid_i,
    input  logic                   mem_ack_i,
    input  logic                   branch_taken_i,
    output logic                   fetch_req_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic                   reg_write_o,
    output logic                   pc_write_o,
    output logic [1:0]             pc_sel_o,
    output logic                   operand_a_o,
    output logic                   operand_b_o,
    output logic [2:0]             imm_sel,
    output logic [1:0]             mem_to_reg,
    output logic [ALU_CONTROL-1:0] alu_control,
    output logic                   illegal_o,
    output logic                   timeout_o,
    output logic [2:0]             state_o
);
    // state  | meaning
    // FETCH  | request instruction, latch IR on instr_valid_i
    // DECODE | register decoded controls, trap on illegal encoding
    // EXEC   | ALU cycle; branches retire here
    // MEM    | data-memory handshake with timeout counter
    // WB     | register write and PC update
    // TRAP   | absorbing until reset, flags hold

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;
    ctrl_t                  dec_ctrl;
    logic                   dec_illegal;
    logic                   timeout_hit;

    instr_decoder #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .OPCODE     (OPCODE),
        .FUNCTION3  (FUNCTION3)
    ) u_instr_decoder (
        .ir_i     (ir_q),
        .ctrl_o   (dec_ctrl),
        .illegal_o(dec_illegal)
    );

    // this cycle would be the MEM_TIMEOUT-th without an ack
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            FETCH: begin
                if (instr_valid_i) begin
                    ir_d    = instr_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ctrl_d = dec_ctrl;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (ctrl_q.cls)
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_BRANCH:         state_d = FETCH;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_ack_i) begin
                    cnt_d   = '0;
                    state_d = (ctrl_q.cls == CL_STORE) ? FETCH : WB;
                end else if (timeout_hit) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Retire strobes for branches and stores depend on same-cycle inputs
    always_comb begin
        pc_write_o = 1'b0;
        pc_sel_o   = PC_PLUS4;
        case (state_q)
            EXEC: begin
                if (ctrl_q.cls == CL_BRANCH) begin
                    pc_write_o = 1'b1;
                    pc_sel_o   = branch_taken_i ? PC_IMM : PC_PLUS4;
                end
            end
            MEM: pc_write_o = (ctrl_q.cls == CL_STORE) && mem_ack_i;
            WB: begin
                pc_write_o = 1'b1;
                if (ctrl_q.cls == CL_JAL) begin
                    pc_sel_o = PC_IMM;
                end else if (ctrl_q.cls == CL_JALR) begin
                    pc_sel_o = PC_REG;
                end
            end
            default: pc_write_o = 1'b0;
        endcase
    end

    assign fetch_req_o = (state_q == FETCH);
    assign mem_req_o   = (state_q == MEM);
    assign mem_we_o    = (state_q == MEM) && (ctrl_q.cls == CL_STORE);
    assign reg_write_o = (state_q == WB);
    assign operand_a_o = ctrl_q.op_a;
    assign operand_b_o = ctrl_q.op_b;
    assign imm_sel     = ctrl_q.imm;
    assign mem_to_reg  = ctrl_q.wb_src;
    assign alu_control = ALU_CONTROL'(ctrl_q.alu);
    assign illegal_o   = illegal_q;
    assign timeout_o   = timeout_q;
    assign state_o     = state_q;

endmodule
